iob_uart16550_console: RTL and testbench

- IOb-native bus initiator that drives an iob_uart16550 register file.
- Counterpart to the tester-side UART port: testbenches and the SoC-side console get a byte-stream view (TX/RX valid/ready) instead of hand-sequenced register accesses.
- Programs the divisor and line control after reset, then polls LSR, pulls received bytes from RBR and pushes transmit bytes into THR.

---
 rtl/iob_uart16550_console_pkg.sv | 38 +++
 rtl/iob_uart16550_console_xfer.sv | 102 ++++++++++
 rtl/iob_uart16550_console.sv | 142 ++++++++++++++
 tb/tb_iob_uart16550_console.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_uart16550_console_pkg.sv
// Shared constants for the iob_uart16550 console: register byte offsets,
// LSR bit positions, line-control values and FSM state encodings.
package iob_uart16550_console_pkg;

  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL     = 3'd0;
  localparam logic [2:0] ADDR_DLM     = 3'd1;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_LSR     = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;

  typedef enum logic [2:0] {
    INIT_LCR_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    POLL,
    DECIDE,
    RD_RBR,
    WR_THR
  } state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_REQ,
    X_WAIT_RV
  } xfer_state_t;

  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/iob_uart16550_console_xfer.sv
// Single-transaction IOb initiator: one request in flight, completes on ready
// (writes) or rvalid (reads). Bus timeout enabled by IOB_UART16550_CONSOLE_TIMEOUT_EN.
module iob_uart16550_console_xfer
  import iob_uart16550_console_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wbyte_i,
  input  logic              we_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [7:0]        rbyte_o,
  output logic              iob_avalid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [3:0]        iob_wstrb_o,
  input  logic [DATA_W-1:0] iob_rdata_i,
  input  logic              iob_rvalid_i,
  input  logic              iob_ready_i
);

  xfer_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wbyte_q;
  logic              we_q;
  logic [1:0]        lane;
  logic [DATA_W-1:0] rdata_sh;
  logic              done_raw;
  logic              to_raw;

  assign lane         = addr_q[1:0];
  assign rdata_sh     = iob_rdata_i >> {lane, 3'b000};
  assign rbyte_o      = rdata_sh[7:0];
  assign iob_avalid_o = (state_q == X_REQ);
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = {(DATA_W/8){wbyte_q}};
  assign iob_wstrb_o  = we_q ? lane_strb(lane) : 4'b0000;
  assign busy_o       = (state_q != X_IDLE);

  // rvalid may coincide with ready; a read only needs to wait when it does not.
  assign done_raw = ((state_q == X_REQ) && iob_ready_i && (we_q || iob_rvalid_i)) ||
                    ((state_q == X_WAIT_RV) && iob_rvalid_i);
  assign done_o    = cke_i && done_raw;
  assign timeout_o = cke_i && to_raw;

`ifdef IOB_UART16550_CONSOLE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  assign to_raw = (state_q != X_IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !done_raw;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      cnt_q <= (state_q == X_IDLE) ? '0 : cnt_q + 1'b1;
    end
  end
`else
  assign to_raw = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      X_IDLE:    if (start_i) state_d = X_REQ;
      X_REQ: begin
        if (to_raw)           state_d = X_IDLE;
        else if (iob_ready_i) state_d = (we_q || iob_rvalid_i) ? X_IDLE : X_WAIT_RV;
      end
      X_WAIT_RV: if (iob_rvalid_i || to_raw) state_d = X_IDLE;
      default:   state_d = X_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= X_IDLE;
      addr_q  <= '0;
      wbyte_q <= '0;
      we_q    <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (state_q == X_IDLE && start_i) begin
        addr_q  <= addr_i;
        wbyte_q <= wbyte_i;
        we_q    <= we_i;
      end
    end
  end

endmodule

// File: rtl/iob_uart16550_console.sv
// Byte-stream console over an iob_uart16550: programs divisor/LCR, then polls
// LSR to move bytes through RBR/THR. Bus timeout enabled by IOB_UART16550_CONSOLE_TIMEOUT_EN.
module iob_uart16550_console
  import iob_uart16550_console_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 3,
  parameter logic [15:0] DIV     = 16'd27,
  parameter int          TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  output logic              iob_avalid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [3:0]        iob_wstrb_o,
  input  logic [DATA_W-1:0] iob_rdata_i,
  input  logic              iob_rvalid_i,
  input  logic              iob_ready_i,
  input  logic [7:0]        tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [7:0]        rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              init_done_o,
  output logic              err_o
);

  state_t            state_q, state_d;
  logic              lsr_dr_q, lsr_thre_q;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q, init_done_q;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_byte;
  logic              req_we, start, xfer_busy, xfer_done, xfer_timeout;
  logic [7:0]        rbyte;

  // Every state except DECIDE owns exactly one bus transaction, launched on entry.
  assign start       = cke_i && (state_q != DECIDE) && !xfer_busy;
  assign tx_ready_o  = start && (state_q == WR_THR);
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign init_done_o = init_done_q;

  iob_uart16550_console_xfer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) u_xfer (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .start_i     (start),
    .addr_i      (req_addr),
    .wbyte_i     (req_byte),
    .we_i        (req_we),
    .busy_o      (xfer_busy),
    .done_o      (xfer_done),
    .timeout_o   (xfer_timeout),
    .rbyte_o     (rbyte),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_rdata_i (iob_rdata_i),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_ready_i (iob_ready_i)
  );

  always_comb begin
    state_d  = state_q;
    req_addr = ADDR_W'(ADDR_LSR);
    req_byte = 8'h00;
    req_we   = 1'b0;
    case (state_q)
      INIT_LCR_DLAB: begin req_addr = ADDR_W'(ADDR_LCR); req_byte = LCR_DLAB_8N1; req_we = 1'b1; end
      INIT_DLL:      begin req_addr = ADDR_W'(ADDR_DLL); req_byte = DIV[7:0];     req_we = 1'b1; end
      INIT_DLM:      begin req_addr = ADDR_W'(ADDR_DLM); req_byte = DIV[15:8];    req_we = 1'b1; end
      INIT_LCR:      begin req_addr = ADDR_W'(ADDR_LCR); req_byte = LCR_8N1;      req_we = 1'b1; end
      RD_RBR:        req_addr = ADDR_W'(ADDR_RBR_THR);
      WR_THR:        begin req_addr = ADDR_W'(ADDR_RBR_THR); req_byte = tx_data_i; req_we = 1'b1; end
      // A full RX holding register masks DR so TX is not starved.
      DECIDE: begin
        if (lsr_dr_q && !rx_valid_q)      state_d = RD_RBR;
        else if (lsr_thre_q && tx_valid_i) state_d = WR_THR;
        else                               state_d = POLL;
      end
      default: ;
    endcase

    if (xfer_timeout) begin
      state_d = init_done_q ? POLL : state_q;
    end else if (xfer_done) begin
      case (state_q)
        INIT_LCR_DLAB: state_d = INIT_DLL;
        INIT_DLL:      state_d = INIT_DLM;
        INIT_DLM:      state_d = INIT_LCR;
        POLL:          state_d = DECIDE;
        default:       state_d = POLL;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= INIT_LCR_DLAB;
      lsr_dr_q    <= 1'b0;
      lsr_thre_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (xfer_done && state_q == POLL) begin
        lsr_dr_q   <= rbyte[LSR_DR];
        lsr_thre_q <= rbyte[LSR_THRE];
      end
      if (xfer_done && state_q == INIT_LCR) init_done_q <= 1'b1;
      if (xfer_done && state_q == RD_RBR) begin
        rx_data_q  <= rbyte;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef IOB_UART16550_CONSOLE_TIMEOUT_EN
  logic err_q;
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                  err_q <= 1'b0;
    else if (cke_i && xfer_timeout) err_q <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_uart16550_console.sv
// Directed bench for iob_uart16550_console: an IOb responder models the UART
// register file and checks every accepted write against a queue of expected writes.
module tb_iob_uart16550_console;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              arst_n_i;
  logic              cke_i;
  logic              iob_avalid_o;
  logic [ADDR_W-1:0] iob_addr_o;
  logic [DATA_W-1:0] iob_wdata_o;
  logic [3:0]        iob_wstrb_o;
  logic [DATA_W-1:0] iob_rdata_i;
  logic              iob_rvalid_i;
  logic              iob_ready_i;
  logic [7:0]        tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [7:0]        rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i;
  logic              init_done_o;
  logic              err_o;

  typedef struct packed {
    logic [2:0] addr;
    logic [3:0] strb;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  wr_t        exp_wr[$];
  logic [3:0] trace[$];
  int         rdy_dly = 0;
  int         rv_dly = 0;
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  int         rd_lsr = 0;
  int         rd_rbr = 0;
  int         tx_ready_cnt = 0;
  int         last_av = 0;
  logic       unstable = 1'b0;

  always #5 clk = ~clk;

  iob_uart16550_console #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DIV    (16'h0102),
    .TIMEOUT(16)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_rdata_i (iob_rdata_i),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_ready_i (iob_ready_i),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .init_done_o (init_done_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk_wr(input logic [2:0] a, input logic [3:0] s, input logic [7:0] d);
    return {a, s, d};
  endfunction

  function automatic logic [31:0] make_rdata(input logic [2:0] a);
    logic [7:0]  v;
    logic [31:0] r;
    v = (a == 3'd5) ? lsr_val : (a == 3'd0) ? rbr_val : 8'h00;
    r = 32'hEEEE_EEEE;
    r[{a[1:0], 3'b000} +: 8] = v;
    return r;
  endfunction

  task automatic push_init_writes();
    exp_wr.push_back(mk_wr(3'd3, 4'b1000, 8'h83));
    exp_wr.push_back(mk_wr(3'd0, 4'b0001, 8'h02));
    exp_wr.push_back(mk_wr(3'd1, 4'b0010, 8'h01));
    exp_wr.push_back(mk_wr(3'd3, 4'b1000, 8'h03));
  endtask

  // Responder: ready after rdy_dly stalled cycles, rvalid rv_dly cycles after ready.
  initial begin : responder
    int          cnt;
    int          rv_wait;
    logic [2:0]  pend_a, a0;
    logic [3:0]  s0;
    logic [31:0] d0, wsh;
    wr_t         got, e;
    cnt = 0; rv_wait = 0; pend_a = '0; a0 = '0; s0 = '0; d0 = '0;
    iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = 32'hDEAD_BEEF;
      if (!arst_n_i) begin
        cnt = 0; rv_wait = 0;
      end else begin
        if (tx_ready_o) tx_ready_cnt++;
        if (rv_wait > 0) begin
          rv_wait--;
          if (rv_wait == 0) begin
            iob_rvalid_i = 1'b1;
            iob_rdata_i  = make_rdata(pend_a);
          end
        end else if (!iob_avalid_o) begin
          cnt = 0;
        end else begin
          if (cnt == 0) begin
            a0 = iob_addr_o; s0 = iob_wstrb_o; d0 = iob_wdata_o;
          end else if (iob_addr_o !== a0 || iob_wstrb_o !== s0 || iob_wdata_o !== d0) begin
            unstable = 1'b1;
          end
          if (cnt >= rdy_dly) begin
            iob_ready_i = 1'b1;
            last_av = cnt + 1;
            cnt = 0;
            trace.push_back({iob_wstrb_o != 4'b0000, iob_addr_o});
            if (iob_wstrb_o != 4'b0000) begin
              wsh = iob_wdata_o >> {iob_addr_o[1:0], 3'b000};
              got = {iob_addr_o, iob_wstrb_o, wsh[7:0]};
              check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
              if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_addr_strb_data", 32'(got), 32'(e));
              end
            end else begin
              if (iob_addr_o == 3'd5) rd_lsr++;
              else if (iob_addr_o == 3'd0) rd_rbr++;
              if (rv_dly == 0) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = make_rdata(iob_addr_o);
              end else begin
                rv_wait = rv_dly;
                pend_a  = iob_addr_o;
              end
            end
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   guard, c0, ri, fw, n;
    logic between;
    arst_n_i = 1'b0; cke_i = 1'b1;
    tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk); #2;
    check("rst_avalid", 32'(iob_avalid_o), 32'd0);
    check("rst_wstrb", 32'(iob_wstrb_o), 32'd0);
    check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check("rst_init_done", 32'(init_done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // Init sequence
    push_init_writes();
    arst_n_i = 1'b1;
    guard = 0;
    while (!init_done_o && guard < 200) begin @(posedge clk); #2; guard++; end
    check("init_done", 32'(init_done_o), 32'd1);
    check("init_writes_left", 32'(exp_wr.size()), 32'd0);
    guard = 0;
    while (rd_lsr < 2 && guard < 200) begin @(posedge clk); #2; guard++; end
    check("lsr_polling", 32'(rd_lsr >= 2), 32'd1);

    // RX: DR set, consumer not ready
    rbr_val = 8'h5A; lsr_val = 8'h01;
    guard = 0;
    while (!rx_valid_o && guard < 200) begin @(posedge clk); #2; guard++; end
    check("rx_valid", 32'(rx_valid_o), 32'd1);
    check("rx_data", 32'(rx_data_o), 32'h5A);
    c0 = rd_rbr;
    repeat (30) @(posedge clk); #2;
    check("rx_full_no_rbr_read", 32'(rd_rbr), 32'(c0));
    check("rx_held", 32'(rx_valid_o), 32'd1);
    lsr_val = 8'h00;
    repeat (10) @(posedge clk); #2;
    rx_ready_i = 1'b1; @(posedge clk); #2; rx_ready_i = 1'b0;
    check("rx_drained", 32'(rx_valid_o), 32'd0);

    // TX: THRE set, one byte pending
    c0 = tx_ready_cnt;
    lsr_val = 8'h20;
    exp_wr.push_back(mk_wr(3'd0, 4'b0001, 8'hA5));
    tx_data_i = 8'hA5; tx_valid_i = 1'b1;
    guard = 0;
    while (tx_ready_cnt == c0 && guard < 200) begin @(posedge clk); #2; guard++; end
    @(posedge clk); #2;
    tx_valid_i = 1'b0; tx_data_i = 8'h00;
    guard = 0;
    while (exp_wr.size() != 0 && guard < 200) begin @(posedge clk); #2; guard++; end
    repeat (20) @(posedge clk); #2;
    check("tx_write_done", 32'(exp_wr.size()), 32'd0);
    check("tx_ready_pulses", 32'(tx_ready_cnt - c0), 32'd1);
    lsr_val = 8'h00;
    repeat (10) @(posedge clk); #2;

    // Priority: DR and THRE together, RX empty, TX pending
    trace.delete();
    rbr_val = 8'h3C; lsr_val = 8'h21;
    c0 = tx_ready_cnt;
    exp_wr.push_back(mk_wr(3'd0, 4'b0001, 8'h77));
    tx_data_i = 8'h77; tx_valid_i = 1'b1;
    guard = 0;
    while (tx_ready_cnt == c0 && guard < 200) begin @(posedge clk); #2; guard++; end
    @(posedge clk); #2;
    tx_valid_i = 1'b0;
    guard = 0;
    while (exp_wr.size() != 0 && guard < 200) begin @(posedge clk); #2; guard++; end
    ri = -1; fw = -1; between = 1'b0;
    foreach (trace[k]) begin
      if (ri < 0 && trace[k] == 4'h0) ri = k;
      if (fw < 0 && trace[k] == 4'h8) fw = k;
    end
    for (int k = 0; k < trace.size(); k++)
      if (k > ri && k < fw && trace[k] == 4'h5) between = 1'b1;
    check("prio_rbr_seen", 32'(ri >= 0), 32'd1);
    check("prio_rbr_before_thr", 32'(fw > ri), 32'd1);
    check("prio_lsr_repoll", 32'(between), 32'd1);
    check("prio_rx_data", 32'(rx_data_o), 32'h3C);
    lsr_val = 8'h00;
    repeat (10) @(posedge clk); #2;
    rx_ready_i = 1'b1; @(posedge clk); #2; rx_ready_i = 1'b0;

    // Slow responder: ready after 5 stalls, rvalid 3 cycles later
    repeat (10) @(posedge clk); #2;
    rdy_dly = 5; rv_dly = 3;
    repeat (20) @(posedge clk); #2;
    unstable = 1'b0;
    rbr_val = 8'h96; lsr_val = 8'h01;
    guard = 0;
    while (!rx_valid_o && guard < 300) begin @(posedge clk); #2; guard++; end
    check("slow_rx_data", 32'(rx_data_o), 32'h96);
    check("slow_avalid_cycles", 32'(last_av), 32'd6);
    check("slow_req_stable", 32'(unstable), 32'd0);
    rdy_dly = 0; rv_dly = 0; lsr_val = 8'h00;
    repeat (30) @(posedge clk); #2;
    rx_ready_i = 1'b1; @(posedge clk); #2; rx_ready_i = 1'b0;
    check("err_clear", 32'(err_o), 32'd0);

    // Reset while a request is stalled
    rdy_dly = 1000;
    guard = 0;
    while (!iob_avalid_o && guard < 100) begin @(posedge clk); #2; guard++; end
    check("stall_avalid_up", 32'(iob_avalid_o), 32'd1);
    repeat (3) @(posedge clk); #3;
    arst_n_i = 1'b0; #1;
    check("rst_mid_avalid", 32'(iob_avalid_o), 32'd0);
    check("rst_mid_init_done", 32'(init_done_o), 32'd0);
    rdy_dly = 0;
    push_init_writes();
    @(posedge clk); #3;
    arst_n_i = 1'b1;
    guard = 0;
    while (!init_done_o && guard < 200) begin @(posedge clk); #2; guard++; end
    check("reinit_done", 32'(init_done_o), 32'd1);
    check("reinit_writes_left", 32'(exp_wr.size()), 32'd0);

`ifdef IOB_UART16550_CONSOLE_TIMEOUT_EN
    // Ready stuck low: request abandoned after TIMEOUT cycles
    repeat (5) @(posedge clk); #2;
    rdy_dly = 1000;
    guard = 0;
    while (!iob_avalid_o && guard < 100) begin @(posedge clk); #2; guard++; end
    n = 0;
    while (iob_avalid_o && n < 100) begin n++; @(posedge clk); #2; end
    check("to_avalid_cycles", 32'(n), 32'd16);
    check("to_err_set", 32'(err_o), 32'd1);
    rdy_dly = 0;
    c0 = rd_lsr;
    repeat (30) @(posedge clk); #2;
    check("to_err_sticky", 32'(err_o), 32'd1);
    check("to_resumed_polling", 32'(rd_lsr > c0), 32'd1);
`else
    n = 0;
    check("err_tied_low", 32'(err_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
